// File: rtl/instruction_memory_pkg.sv
// Shared constants for the instruction memory: default depth, the filler
// word returned for unmapped fetches, and the boot image loaded on reset.
package instruction_memory_pkg;

  localparam int unsigned DEPTH_DEFAULT = 256;

  // MIPS "sll $0,$0,0": the canonical no-op encoding.
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

  // addi $t0,$zero,5 / addi $t1,$zero,3
  localparam logic [31:0] BOOT_WORD0 = 32'h2008_0005;
  localparam logic [31:0] BOOT_WORD1 = 32'h2009_0003;

  // Boot-image content for a given word index; every word past the two
  // boot instructions is filled with the supplied no-op.
  function automatic logic [31:0] boot_word(input int unsigned idx,
                                            input logic [31:0] nop);
    case (idx)
      0:       return BOOT_WORD0;
      1:       return BOOT_WORD1;
      default: return nop;
    endcase
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-organised instruction memory with combinational fetch and a
// synchronous program-load write port. Storage is a flop array that is
// asynchronously preset to the boot image while rst is high.
//
// Ports:
//   clk          - clock; program-load writes sample on the rising edge
//   rst          - asynchronous active-high reset (loads boot image)
//   Address      - byte address of the instruction fetch (PC)
//   Instruction  - word at Address[31:2], or NOP_WORD when out of range
//   we           - program-load write enable
//   wr_addr      - byte address of the program-load write
//   wr_data      - word to store
//   misaligned   - Address[1:0] != 0 (does not affect Instruction)
//   out_of_range - Address[31:2] >= DEPTH (no wrap-around)
module instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter int unsigned DEPTH    = instruction_memory_pkg::DEPTH_DEFAULT,
  parameter logic [31:0] NOP_WORD = instruction_memory_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  output logic [31:0] Instruction,
  input  logic        we,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        misaligned,
  output logic        out_of_range
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [31:0] mem_q [DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_in_range;
  logic             wr_en_d;
  logic             unused_wr_lsbs;

  // Range checks use the full 30-bit word index so that high addresses
  // never alias onto low words through truncation.
  assign out_of_range   = (Address[31:2] >= 30'(DEPTH));
  assign wr_in_range    = (wr_addr[31:2] <  30'(DEPTH));
  assign misaligned     = (Address[1:0] != 2'b00);
  assign unused_wr_lsbs = ^wr_addr[1:0];

  assign rd_idx  = Address[IDX_W+1:2];
  assign wr_idx  = wr_addr[IDX_W+1:2];
  assign wr_en_d = we && wr_in_range;

  always_comb begin
    Instruction = NOP_WORD;
    if (!out_of_range) begin
      Instruction = mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= boot_word(i, NOP_WORD);
      end
    end else if (wr_en_d) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory. A word-array model tracks the
// expected contents; a negedge process compares every output against it,
// and literal checks pin the model to the hand-computed values.
module tb_instruction_memory;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Address = '0;
  logic [31:0] Instruction;
  logic        we = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        misaligned;
  logic        out_of_range;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit          cmp_en = 1'b0;

  logic [31:0] model [DEPTH];

  instruction_memory #(.DEPTH(DEPTH), .NOP_WORD(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .Address      (Address),
    .Instruction  (Instruction),
    .we           (we),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .misaligned   (misaligned),
    .out_of_range (out_of_range)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_boot();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
    model[0] = 32'h2008_0005;
    model[1] = 32'h2009_0003;
  endtask

  function automatic logic [31:0] model_instr(input logic [31:0] a);
    logic [31:0] idx;
    idx = a >> 2;
    if (idx >= DEPTH) return 32'h0;
    return model[idx];
  endfunction

  function automatic logic model_oor(input logic [31:0] a);
    return (a >> 2) >= DEPTH;
  endfunction

  // Continuous comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_instr", Instruction, model_instr(Address));
      chk("model_mis",   {31'b0, misaligned},   {31'b0, (Address % 4) != 0});
      chk("model_oor",   {31'b0, out_of_range}, {31'b0, model_oor(Address)});
    end
  end

  task automatic fetch(input logic [31:0] a);
    Address = a;
    #1;
  endtask

  // One-edge program-load write; model follows only if the write is legal.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    we = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    if (!rst && (a >> 2) < DEPTH) model[a >> 2] = d;
    we = 1'b0;
  endtask

  initial begin
    model_boot();
    #2 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Boot image after reset release
    fetch(32'd0);
    chk("boot_w0", Instruction, 32'h2008_0005);
    chk("boot_mis0", {31'b0, misaligned}, 32'd0);
    chk("boot_oor0", {31'b0, out_of_range}, 32'd0);
    fetch(32'd4);
    chk("boot_w1", Instruction, 32'h2009_0003);
    fetch(32'd8);
    chk("boot_w2", Instruction, 32'h0000_0000);

    // Basic write and misaligned fetch of the same word
    do_write(32'd8, 32'hDEAD_BEEF);
    fetch(32'd8);
    chk("wr_w2", Instruction, 32'hDEAD_BEEF);
    fetch(32'd10);
    chk("mis_w2", Instruction, 32'hDEAD_BEEF);
    chk("mis_flag", {31'b0, misaligned}, 32'd1);
    chk("mis_oor", {31'b0, out_of_range}, 32'd0);

    // Misaligned write address lands on word 5
    do_write(32'h0000_0017, 32'hA5A5_0017);
    fetch(32'd20);
    chk("wr_lsb_ign", Instruction, 32'hA5A5_0017);

    // Boundaries: last word, first out-of-range word, top of address space
    do_write(32'd60, 32'h0BAD_F00D);
    fetch(32'd60);
    chk("last_word", Instruction, 32'h0BAD_F00D);
    chk("last_oor", {31'b0, out_of_range}, 32'd0);
    fetch(DEPTH * 4);
    chk("oor_instr", Instruction, 32'h0000_0000);
    chk("oor_flag", {31'b0, out_of_range}, 32'd1);
    fetch(32'hFFFF_FFFC);
    chk("top_instr", Instruction, 32'h0000_0000);
    chk("top_oor", {31'b0, out_of_range}, 32'd1);

    // Out-of-range writes are dropped (including ones that would alias)
    do_write(DEPTH * 4, 32'h5555_5555);
    do_write(32'hFFFF_FFF8, 32'h6666_6666);
    do_write(32'h0000_0400, 32'h7777_7777);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fetch(32'(i * 4));
      chk("oor_wr_sweep", Instruction, model_instr(32'(i * 4)));
    end
    fetch(32'd0);
    chk("oor_wr_w0", Instruction, 32'h2008_0005);
    fetch(32'd56);
    chk("oor_wr_w14", Instruction, 32'h0000_0000);

    // Read-during-write: old word before the edge, new word after
    Address = 32'd12;
    @(posedge clk); #1;
    we = 1'b1; wr_addr = 32'd12; wr_data = 32'hCAFE_F00D;
    #2;
    chk("rdw_before", Instruction, 32'h0000_0000);
    @(posedge clk); #1;
    model[3] = 32'hCAFE_F00D;
    we = 1'b0;
    chk("rdw_after", Instruction, 32'hCAFE_F00D);

    // Asynchronous reset mid-cycle restores the boot image immediately
    do_write(32'd0, 32'h1234_5678);
    fetch(32'd0);
    chk("w0_written", Instruction, 32'h1234_5678);
    #2;
    rst = 1'b1;
    model_boot();
    #1;
    chk("async_rst_w0", Instruction, 32'h2008_0005);
    fetch(32'd8);
    chk("async_rst_w2", Instruction, 32'h0000_0000);

    // Writes are ignored while reset is held
    do_write(32'd4, 32'h9999_9999);
    fetch(32'd4);
    chk("rst_wr_ign", Instruction, 32'h2009_0003);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    fetch(32'd12);
    chk("post_rst_w3", Instruction, 32'h0000_0000);
    repeat (2) @(posedge clk);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_memory.md
INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 Parameter: DEPTH, 256, number of 32-bit words stored (power of two, 16..1024).
REQ-002 Parameter: NOP_WORD, 32'h0000_0000, word returned for out-of-range reads (MIPS sll $0,$0,0).
REQ-003 clk  input  1  single clock; all writes sample on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 Address  input  32  byte address of instruction fetch (PC).
REQ-006 Instruction  output  32  instruction word at Address.
REQ-007 we  input  1  program-load write enable.
REQ-008 wr_addr  input  32  byte address of program-load write.
REQ-009 wr_data  input  32  word to store.
REQ-010 misaligned  output  1  high when Address[1:0] != 2'b00.
REQ-011 out_of_range  output  1  high when word index Address[31:2] >= DEPTH.

Function
REQ-012 Memory is word-organised; word index = Address[31:2]; Address[1:0] ignored for data selection.
REQ-013 Read is combinational: Instruction reflects Address and current contents with zero clock latency.
REQ-014 In range, Instruction = mem[Address[31:2]]; out of range, Instruction = NOP_WORD.
REQ-015 misaligned and out_of_range are combinational; misaligned does not alter Instruction.
REQ-016 On rising clk with we=1, rst=0, wr_addr[31:2] < DEPTH: mem[wr_addr[31:2]] <= wr_data; wr_addr[1:0] ignored.
REQ-017 Write with wr_addr[31:2] >= DEPTH is silently dropped; no state changes.
REQ-018 Read-during-write to the same word: Instruction shows old word until the edge, new word immediately after (no bypass).
REQ-019 Address 32'hFFFF_FFFC and any address above DEPTH*4-1 are out of range; no wrap-around.

Reset
REQ-020 While rst=1, the array holds the boot image asynchronously and writes are ignored.
REQ-021 Boot image: word 0 = 32'h2008_0005 (addi $t0,$zero,5), word 1 = 32'h2009_0003 (addi $t1,$zero,3), every other word = NOP_WORD.
REQ-022 Outputs during and after reset follow REQ-013..REQ-015 combinationally; no output is registered.

Structure
REQ-023 A shared package holds DEPTH default, NOP_WORD, and the boot-image constants (BOOT_WORD0, BOOT_WORD1).
REQ-024 Single module, no sub-module; storage is a flop array with asynchronous preset to the boot image.

Verification
REQ-025 Pulse rst, release; Address=0 -> Instruction=32'h2008_0005, misaligned=0, out_of_range=0.
REQ-026 After reset, Address=4 -> 32'h2009_0003; Address=8 -> 32'h0000_0000.
REQ-027 Write we=1, wr_addr=8, wr_data=32'hDEAD_BEEF on one edge; Address=8 -> 32'hDEAD_BEEF; Address=10 -> same word, misaligned=1.
REQ-028 Address=DEPTH*4 -> Instruction=NOP_WORD, out_of_range=1; write to wr_addr=DEPTH*4 leaves all words unchanged.
REQ-029 Write 32'h1234_5678 to word 0, then assert rst asynchronously mid-cycle -> Instruction at Address=0 returns 32'h2008_0005 without waiting for a clock edge.
REQ-030 Hold Address=12 while writing 32'hCAFE_F00D to 12 -> Instruction is 0 before the edge and 32'hCAFE_F00D after it.
